ascii_load_sequencer: RTL

- Sequences "Load Ascii" text into the emulated ACIA receive path, from either an HPS file download (ioctl) or the physical UART.
- Buffers incoming bytes in a small FIFO and back-pressures the HPS with ioctl_wait.
- Paces delivery at one character time for the selected baud rate, so BASIC/monitor input handling never overruns.
- Sits between hps_io/UART_RXD and the uk101 ACIA receive port, in the clk_sys domain.

---
 rtl/ascii_load_sequencer.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/ascii_load_sequencer.sv
// ascii_load_sequencer: buffers "Load Ascii" text from hps_io (ioctl) or the UART and
// feeds it to the uk101 ACIA receive port, one character time apart.
// Latency: FIFO pop to rx_valid is 1 cycle; consecutive rx_valid rises are >= GAP+2 cycles apart.
// Backpressure: ioctl_wait (registered) at count >= FIFO_DEPTH-2; rx_valid/rx_data held until rx_ready.
//
// Ports:
//   clk_sys, reset            - clock, synchronous active-high reset
//   load_from, baud_sel       - source select (0 file, 1 UART), pacing (0 9600 baud, 1 300 baud)
//   ioctl_download/wr/index/dout, ioctl_wait - hps_io download port and its stall request
//   uart_rx_valid/uart_rx_data - received UART bytes
//   rx_data/rx_valid/rx_ready  - ACIA receive handshake
//   busy, overflow             - activity flag, sticky drop flag
// Optional build macro: ASCII_LF_TO_CR_EN (LF->CR on push, LF after CR dropped).
module ascii_load_sequencer #(
  parameter int CLK_HZ     = 48000000,
  parameter int FIFO_DEPTH = 16,
  parameter int FILE_INDEX = 0
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       load_from,
  input  logic       baud_sel,
  input  logic       ioctl_download,
  input  logic       ioctl_wr,
  input  logic [7:0] ioctl_index,
  input  logic [7:0] ioctl_dout,
  output logic       ioctl_wait,
  input  logic       uart_rx_valid,
  input  logic [7:0] uart_rx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       overflow
);

  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int GAP_FAST = CLK_HZ / 9600 * 10;
  localparam int GAP_SLOW = CLK_HZ / 30;
  localparam int CW       = $clog2(GAP_SLOW + 1);

  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   WAIT_TH   = (AW+1)'(FIFO_DEPTH - 2);
  localparam logic [CW-1:0] LOAD_FAST = CW'(GAP_FAST - 1);
  localparam logic [CW-1:0] LOAD_SLOW = CW'(GAP_SLOW - 1);
  localparam logic [7:0]    FILE_IDX  = 8'(FILE_INDEX);

  typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [CW-1:0]   gap_q, gap_d;
  logic            src_q, src_d;
  logic            wait_q, wait_d;
  logic            ovf_q, ovf_d;
  logic            rx_valid_q, rx_valid_d;
  logic [7:0]      rx_data_q, rx_data_d;

  logic            push_req, do_push, push_ok, pop;
  logic [7:0]      in_byte, wr_byte;
`ifdef ASCII_LF_TO_CR_EN
  logic            prev_cr_q, prev_cr_d;
`endif

  always_comb begin
    push_req = src_q ? uart_rx_valid
                     : (ioctl_download & ioctl_wr & (ioctl_index == FILE_IDX));
    in_byte  = src_q ? uart_rx_data : ioctl_dout;

    // The source may only change once everything from the old one is delivered.
    src_d = src_q;
    if (state_q == S_IDLE && count_q == '0) src_d = load_from;

`ifdef ASCII_LF_TO_CR_EN
    // Track the raw previous byte: a CR/LF pair collapses to one CR, a bare LF becomes CR.
    prev_cr_d = prev_cr_q;
    do_push   = push_req;
    wr_byte   = in_byte;
    if (push_req) begin
      prev_cr_d = (in_byte == 8'h0D);
      if (in_byte == 8'h0A) begin
        if (prev_cr_q) do_push = 1'b0;
        else           wr_byte = 8'h0D;
      end
    end
    if (src_d != src_q) prev_cr_d = 1'b0;
`else
    do_push = push_req;
    wr_byte = in_byte;
`endif

    push_ok = do_push && (count_q != DEPTH_C);
    ovf_d   = ovf_q | (do_push && (count_q == DEPTH_C));
    // Two entries of headroom cover the cycle hps_io needs to react to the stall.
    wait_d  = !src_q && (count_q >= WAIT_TH);

    pop        = 1'b0;
    state_d    = state_q;
    gap_d      = gap_q;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop        = 1'b1;
          rx_data_d  = mem_q[rd_ptr_q];
          rx_valid_d = 1'b1;
          state_d    = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (rx_ready) begin
          rx_valid_d = 1'b0;
          gap_d      = baud_sel ? LOAD_SLOW : LOAD_FAST;
          state_d    = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      gap_q      <= '0;
      src_q      <= load_from;
      wait_q     <= 1'b0;
      ovf_q      <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
`ifdef ASCII_LF_TO_CR_EN
      prev_cr_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      gap_q      <= gap_d;
      src_q      <= src_d;
      wait_q     <= wait_d;
      ovf_q      <= ovf_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
`ifdef ASCII_LF_TO_CR_EN
      prev_cr_q  <= prev_cr_d;
`endif
    end
  end

  // Storage needs no reset: count_q alone decides which entries are live.
  always_ff @(posedge clk_sys) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_byte;
  end

  assign ioctl_wait = wait_q;
  assign overflow   = ovf_q;
  assign rx_valid   = rx_valid_q;
  assign rx_data    = rx_data_q;
  assign busy       = (count_q != '0) || (state_q != S_IDLE);

endmodule
